fetch_unit: RTL and testbench

Instruction-fetch and memory-access sequencer sitting directly upstream of the 256x8 unified memory.
- Sole driver of the memory's address, write-enable and write-data inputs.
- Fetches instructions at the program counter and hands them to the execute stage over a valid/ready handshake.
- Arbitrates the execute stage's data load/store requests onto the same single memory port.
- Memory read is combinational; memory write commits on posedge clk when rw=1.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/memory-access sequencer: sequencer states,
// instruction field positions, the data page constant and bus widths.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Sequencer states; the encoding is visible on fetch_unit.state_dbg.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_ISSUE  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // Instruction field positions used by the execute stage.
    localparam int OPC_MSB      = 7;
    localparam int OPC_LSB      = 4;
    localparam int RD_MSB       = 3;
    localparam int RD_LSB       = 2;
    localparam int RS_MSB       = 1;
    localparam int RS_LSB       = 0;
    localparam int PAGE_OFS_MSB = 3;
    localparam int PAGE_OFS_LSB = 0;

    // Upper address nibble of the data page.
    localparam logic [3:0] DATA_PAGE = 4'hF;

    // Extract the opcode field of an instruction byte.
    function automatic logic [3:0] opcode_of(input logic [DATA_W-1:0] ins);
        return ins[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: sole master of the 256x8 unified memory port. Fetches the
// instruction at pc, offers it to execute (instr_valid/instr_ready), then
// serves execute's load/store requests until exec_done redirects, advances
// or halts the core.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. instr_valid holds instr stable until that edge; dreq_ready is 1
// for the whole EXEC state and a request is taken on the edge where
// dreq_valid is also 1. drsp_valid is a one-cycle pulse with no back-pressure.
//
// Build option: define WRITE_PROTECT_EN to suppress stores to addresses below
// PROT_LIMIT and record them in the sticky wp_fault flag.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 8'h00,
    parameter logic [ADDR_W-1:0] PROT_LIMIT = 8'h10
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              dreq_valid,
    input  logic              dreq_we,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [DATA_W-1:0] dreq_wdata,
    output logic              dreq_ready,
    output logic [DATA_W-1:0] drsp_data,
    output logic              drsp_valid,
    input  logic              exec_done,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic              wp_fault,
    output state_e            state_dbg
);

`ifdef WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [DATA_W-1:0]   instr_q;
    logic                instr_valid_q;
    logic                dreq_ready_q;
    logic [ADDR_W-1:0]   daddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   drsp_data_q;
    logic                drsp_valid_q;
    logic                mem_rw_q;
    logic                halted_q;
    logic                wp_fault_q;
    logic                store_blocked;

    // A store is blocked when protection is built in and it targets the low region.
    assign store_blocked = WP_EN && (dreq_addr < PROT_LIMIT);

    // Sequencer FSM with all control outputs registered; mem_rw is registered
    // so the asynchronous reset removes a write strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            dreq_ready_q  <= 1'b0;
            daddr_q       <= '0;
            wdata_q       <= '0;
            drsp_data_q   <= '0;
            drsp_valid_q  <= 1'b0;
            mem_rw_q      <= 1'b0;
            halted_q      <= 1'b0;
            wp_fault_q    <= 1'b0;
        end else begin
            drsp_valid_q <= 1'b0;
            mem_rw_q     <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    instr_q       <= mem_rdata;
                    pc_q          <= pc_q + 8'd1;
                    instr_valid_q <= 1'b1;
                    state_q       <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        dreq_ready_q  <= 1'b1;
                        state_q       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A data request takes priority over exec_done.
                    if (dreq_valid) begin
                        daddr_q      <= dreq_addr;
                        wdata_q      <= dreq_wdata;
                        dreq_ready_q <= 1'b0;
                        if (dreq_we) begin
                            state_q <= S_MEM_WR;
                            if (store_blocked) begin
                                wp_fault_q <= 1'b1;
                            end else begin
                                mem_rw_q <= 1'b1;
                            end
                        end else begin
                            state_q <= S_MEM_RD;
                        end
                    end else if (exec_done) begin
                        dreq_ready_q <= 1'b0;
                        if (halt_req) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            if (branch_valid) begin
                                pc_q <= branch_target;
                            end
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_MEM_RD: begin
                    drsp_data_q  <= mem_rdata;
                    drsp_valid_q <= 1'b1;
                    dreq_ready_q <= 1'b1;
                    state_q      <= S_EXEC;
                end
                S_MEM_WR: begin
                    dreq_ready_q <= 1'b1;
                    state_q      <= S_EXEC;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Memory address: data address during access cycles, otherwise the pc.
    always_comb begin
        mem_addr = pc_q;
        if ((state_q == S_MEM_RD) || (state_q == S_MEM_WR)) begin
            mem_addr = daddr_q;
        end
    end

    assign mem_rw      = mem_rw_q;
    assign mem_wdata   = wdata_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign dreq_ready  = dreq_ready_q;
    assign drsp_data   = drsp_data_q;
    assign drsp_valid  = drsp_valid_q;
    assign halted      = halted_q;
    assign pc          = pc_q;
    assign wp_fault    = wp_fault_q;
    assign state_dbg   = state_q;

    // Execute must not raise a data request and exec_done in the same cycle.
    req_with_done_a: assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == S_EXEC) && dreq_valid && exec_done));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural memory, a reference model of program
// flow and memory contents, a driver acting as execute stage, and a monitor
// that checks DUT outputs against queued expectations.
module tb_fetch_unit;
  import cpu_pkg::*;

`ifdef WRITE_PROTECT_EN
  localparam bit WP_EN_TB = 1'b1;
`else
  localparam bit WP_EN_TB = 1'b0;
`endif
  localparam logic [7:0] PROT_LIMIT_TB = 8'h10;
  localparam logic [7:0] RESET_PC_TB   = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, instr, drsp_data, pc;
  logic [7:0] dreq_addr, dreq_wdata, branch_target;
  logic       mem_rw, instr_valid, instr_ready, dreq_valid, dreq_we, dreq_ready;
  logic       drsp_valid, exec_done, branch_valid, halt_req, halted, wp_fault;
  state_e     state_dbg;

  fetch_unit #(.RESET_PC(RESET_PC_TB), .PROT_LIMIT(PROT_LIMIT_TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
    .dreq_wdata(dreq_wdata), .dreq_ready(dreq_ready),
    .drsp_data(drsp_data), .drsp_valid(drsp_valid),
    .exec_done(exec_done), .branch_valid(branch_valid), .branch_target(branch_target),
    .halt_req(halt_req), .halted(halted), .pc(pc), .wp_fault(wp_fault),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_rw) mem[mem_addr] <= mem_wdata;

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] ref_mem [256];
  logic [7:0] model_pc;
  bit         model_wp;
  logic [7:0] exp_instr_q[$];
  logic [7:0] exp_pc_q[$];
  logic [7:0] exp_wa_q[$];
  logic [7:0] exp_wd_q[$];
  logic [7:0] exp_rd_q[$];
  int         exp_rc_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next fetch reads the model memory at the model pc; pc shows pc+1 afterwards.
  task automatic push_fetch();
    exp_instr_q.push_back(ref_mem[model_pc]);
    exp_pc_q.push_back(model_pc + 8'd1);
    model_pc = model_pc + 8'd1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid) begin
        if (exp_instr_q.size() == 0) check("instr_unexpected", 1, 0);
        else begin
          check("instr", instr, exp_instr_q[0]);
          check("pc_issue", pc, exp_pc_q[0]);
          if (instr_ready) begin
            void'(exp_instr_q.pop_front());
            void'(exp_pc_q.pop_front());
          end
        end
      end
      if (mem_rw) begin
        if (exp_wa_q.size() == 0) check("mem_rw_unexpected", 1, 0);
        else begin
          check("wr_addr", mem_addr, exp_wa_q.pop_front());
          check("wr_data", mem_wdata, exp_wd_q.pop_front());
        end
      end
      if (drsp_valid) begin
        if (exp_rd_q.size() == 0) check("drsp_unexpected", 1, 0);
        else begin
          check("drsp_data", drsp_data, exp_rd_q.pop_front());
          check("drsp_latency", cyc, exp_rc_q.pop_front());
        end
      end
      check("wp_fault", wp_fault, model_wp);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_state();
    check("rst_pc", pc, RESET_PC_TB);
    check("rst_state", state_dbg, S_FETCH);
    check("rst_instr", instr, 8'h00);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_dreq_ready", dreq_ready, 0);
    check("rst_drsp_valid", drsp_valid, 0);
    check("rst_drsp_data", drsp_data, 8'h00);
    check("rst_halted", halted, 0);
    check("rst_wp_fault", wp_fault, 0);
    check("rst_mem_rw", mem_rw, 0);
    check("rst_mem_wdata", mem_wdata, 8'h00);
  endtask

  // Wait for the instruction handshake, keeping ready low for hold_low tries.
  task automatic wait_issue(input int hold_low);
    int  waited = 0;
    bit  hs = 1'b0;
    if (abort) return;
    while (!hs && waited < 60) begin
      @(posedge clk); #1;
      instr_ready = (waited >= hold_low) ? ($urandom_range(0, 3) != 0) : 1'b0;
      @(negedge clk);
      hs = instr_valid && instr_ready;
      waited++;
    end
    if (!hs) begin
      check("issue_timeout", 0, 1);
      abort = 1'b1;
      return;
    end
    @(posedge clk); #1;
    instr_ready = 1'b0;
  endtask

  // One data access issued from EXEC; returns in EXEC one cycle later.
  task automatic do_op(input bit we, input logic [7:0] a, input logic [7:0] d);
    if (abort) return;
    check("dreq_ready_exec", dreq_ready, 1);
    dreq_valid = 1'b1; dreq_we = we; dreq_addr = a; dreq_wdata = d;
    @(posedge clk); #1;
    dreq_valid = 1'b0; dreq_we = 1'b0;
    if (we) begin
      if (WP_EN_TB && (a < PROT_LIMIT_TB)) model_wp = 1'b1;
      else begin
        ref_mem[a] = d;
        exp_wa_q.push_back(a);
        exp_wd_q.push_back(d);
      end
    end else begin
      exp_rd_q.push_back(ref_mem[a]);
      exp_rc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
  endtask

  // br_mode: 0 no branch, 1 random branch, 2 branch to tgt.
  task automatic finish_instr(input int br_mode, input logic [7:0] tgt, input bit halt);
    bit br;
    if (abort) return;
    check("dreq_ready_done", dreq_ready, 1);
    br = (br_mode == 1) ? ($urandom_range(0, 3) == 0) : (br_mode == 2);
    exec_done = 1'b1;
    halt_req = halt;
    branch_valid = br;
    branch_target = (br_mode == 2) ? tgt : 8'($urandom);
    if (!halt && br) model_pc = branch_target;
    @(posedge clk); #1;
    exec_done = 1'b0; halt_req = 1'b0; branch_valid = 1'b0;
    if (!halt) push_fetch();
  endtask

  task automatic random_ops();
    int n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++)
      do_op($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; instr_ready = 1'b0; dreq_valid = 1'b0; dreq_we = 1'b0;
    dreq_addr = '0; dreq_wdata = '0; exec_done = 1'b0; branch_valid = 1'b0;
    branch_target = '0; halt_req = 1'b0; model_wp = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h21; mem[1] = 8'h1B; mem[2] = 8'h20; mem[3] = 8'h0B; mem[4] = 8'h30;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    repeat (3) @(posedge clk);
    #1 check_reset_state();
    model_pc = RESET_PC_TB;
    push_fetch();
    rst_n = 1'b1;

    // Straight-line program from address 00.
    for (int i = 0; i < 5; i++) begin
      wait_issue(0);
      finish_instr(0, 8'h00, 1'b0);
    end
    // Store FB, then branch to FF to exercise pc wrap.
    wait_issue(0);
    do_op(1'b1, 8'hFB, 8'h01);
    finish_instr(2, 8'hFF, 1'b0);
    // Fetch at FF, then fall through to 00; load-after-store to FB.
    wait_issue(0);
    do_op(1'b1, 8'hFB, 8'hAA);
    do_op(1'b0, 8'hFB, 8'h00);
    finish_instr(0, 8'h00, 1'b0);
    // Ready held low; store/load to a low address.
    wait_issue(6);
    do_op(1'b1, 8'h05, 8'h77);
    do_op(1'b0, 8'h05, 8'h00);
    finish_instr(0, 8'h00, 1'b0);
    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      wait_issue($urandom_range(0, 2));
      random_ops();
      finish_instr(1, 8'h00, 1'b0);
    end

    // Reset asserted in the middle of a write cycle.
    wait_issue(0);
    if (!abort) begin
      dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 8'h80; dreq_wdata = 8'h5A;
      @(posedge clk); #1;
      dreq_valid = 1'b0; dreq_we = 1'b0;
      check("memwr_rw", mem_rw, 1);
      check("memwr_addr", mem_addr, 8'h80);
      rst_n = 1'b0;
      #1 check("rst_async_rw", mem_rw, 0);
      check_reset_state();
      repeat (2) @(posedge clk);
      #1;
      model_pc = RESET_PC_TB;
      model_wp = 1'b0;
      push_fetch();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        wait_issue(0);
        random_ops();
        finish_instr(1, 8'h00, 1'b0);
      end
      // Halt and verify nothing else is fetched.
      wait_issue(0);
      finish_instr(0, 8'h00, 1'b1);
      for (int i = 0; i < 10 && !abort; i++) begin
        @(negedge clk);
        check("halted", halted, 1);
        check("halt_state", state_dbg, S_HALT);
        check("halt_no_fetch", instr_valid, 0);
        check("halt_pc", pc, model_pc);
      end
    end

    check("left_instr", exp_instr_q.size(), 0);
    check("left_writes", exp_wa_q.size(), 0);
    check("left_loads", exp_rd_q.size(), 0);
    for (int i = 0; i < 256; i++) check("mem_final", mem[i], ref_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
